read_ar_arbiter: RTL and testbench

Two-port read-address arbiter and read-data router between the two AR request FIFOs and the single AXI3 read master channel (AR + R) feeding the read slave/memory. It accepts packed 50-bit AR descriptors from two requesters and grants them round-robin, subject to a per-port outstanding-burst limit. It drives one AR transaction at a time with ARID set to the granted port index, and steers R beats back to the owning port by RID.

---
 rtl/read_ar_arbiter.sv | 143 ++++++++++++++
 tb/tb_read_ar_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_ar_arbiter.sv
// Two-port read-address arbiter with outstanding-burst limits and R routing.
// Ports are granted round-robin. One AR transaction is in flight at a time,
// and ARID carries the index of the granted port. R beats are steered back
// to their owner by RID.
module read_ar_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        req0_valid,
    input  logic [49:0] req0_desc,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [49:0] req1_desc,
    output logic        req1_ready,
    output logic        ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [1:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic [1:0]  ARLOCK,
    output logic [3:0]  ARCACHE,
    output logic [2:0]  ARPROT,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic        RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic        r0_valid,
    output logic [31:0] r0_data,
    output logic [1:0]  r0_resp,
    output logic        r0_last,
    input  logic        r0_ready,
    output logic        r1_valid,
    output logic [31:0] r1_data,
    output logic [1:0]  r1_resp,
    output logic        r1_last,
    input  logic        r1_ready,
    output logic [1:0]  out0_cnt,
    output logic [1:0]  out1_cnt
);

    // state | meaning
    // IDLE  | no AR pending; pick an eligible port
    // ISSUE | AR registers hold a descriptor; ARVALID asserted until ARREADY
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        elig0, elig1, grant_any, grant_port;
    logic        ar_hs, inc0, inc1, dec0, dec1;
    logic [49:0] sel_desc;

    // The tag bit of each descriptor is not used, because ARID comes from the port index.
    logic unused_tag;
    assign unused_tag = req0_desc[49] ^ req1_desc[49];

    assign elig0      = req0_valid && (out0_cnt < MAX_CNT);
    assign elig1      = req1_valid && (out1_cnt < MAX_CNT);
    assign grant_any  = (state == IDLE) && (elig0 || elig1);
    // When both ports are eligible, the port that did not win last time is granted.
    assign grant_port = (elig0 && elig1) ? ~last_grant : elig1;
    assign sel_desc   = grant_port ? req1_desc : req0_desc;

    assign ar_hs = ARVALID && ARREADY;
    assign inc0  = ar_hs && !ARID;
    assign inc1  = ar_hs && ARID;
    // A completion at zero count is ignored, so the counter saturates at zero.
    assign dec0  = RVALID && RREADY && RLAST && !RID && (out0_cnt != 2'd0);
    assign dec1  = RVALID && RREADY && RLAST && RID  && (out1_cnt != 2'd0);

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   if (ARREADY)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs. The ready pulse is gated by reset so that no descriptor
    // is consumed while the block is held in reset.
    always_comb begin
        ARVALID    = (state == ISSUE);
        req0_ready = ARESETn && grant_any && !grant_port;
        req1_ready = ARESETn && grant_any && grant_port;
    end

    // AR field capture, round-robin pointer and outstanding counters
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ARID       <= 1'b0;
            ARADDR     <= '0;
            ARLEN      <= '0;
            ARSIZE     <= '0;
            ARBURST    <= '0;
            ARLOCK     <= '0;
            ARCACHE    <= '0;
            ARPROT     <= '0;
            last_grant <= 1'b1;
            out0_cnt   <= 2'd0;
            out1_cnt   <= 2'd0;
        end else begin
            if (grant_any) begin
                ARID    <= grant_port;
                ARADDR  <= sel_desc[48:17];
                ARLEN   <= sel_desc[16:13];
                ARSIZE  <= sel_desc[12:11];
                ARBURST <= sel_desc[10:9];
                ARLOCK  <= sel_desc[8:7];
                ARCACHE <= sel_desc[6:3];
                ARPROT  <= sel_desc[2:0];
            end
            if (ar_hs) last_grant <= ARID;
            out0_cnt <= out0_cnt + {1'b0, inc0} - {1'b0, dec0};
            out1_cnt <= out1_cnt + {1'b0, inc1} - {1'b0, dec1};
        end
    end

    // R routing is purely combinational.
    assign r0_valid = RVALID && !RID;
    assign r1_valid = RVALID && RID;
    assign RREADY   = RID ? r1_ready : r0_ready;
    assign r0_data  = RDATA;
    assign r1_data  = RDATA;
    assign r0_resp  = RRESP;
    assign r1_resp  = RRESP;
    assign r0_last  = RLAST;
    assign r1_last  = RLAST;

endmodule

// File: tb/tb_read_ar_arbiter.sv
module tb_read_ar_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [49:0] req0_desc, req1_desc;
    logic        ARID, ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN, ARCACHE;
    logic [1:0]  ARSIZE, ARBURST, ARLOCK;
    logic [2:0]  ARPROT;
    logic        RID, RLAST, RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        r0_valid, r0_last, r0_ready, r1_valid, r1_last, r1_ready;
    logic [31:0] r0_data, r1_data;
    logic [1:0]  r0_resp, r1_resp, out0_cnt, out1_cnt;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    read_ar_arbiter #(.MAX_OUT(2)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req0_valid(req0_valid), .req0_desc(req0_desc), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_desc(req1_desc), .req1_ready(req1_ready),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .r0_valid(r0_valid), .r0_data(r0_data), .r0_resp(r0_resp), .r0_last(r0_last),
        .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_data(r1_data), .r1_resp(r1_resp), .r1_last(r1_last),
        .r1_ready(r1_ready),
        .out0_cnt(out0_cnt), .out1_cnt(out1_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {tag, addr, len, size, burst=1, lock=0, cache=3, prot=2}; tag set to 1 on purpose
    function automatic logic [49:0] mk_desc(input logic [31:0] a, input logic [3:0] l,
                                            input logic [1:0] s);
        return {1'b1, a, l, s, 2'b01, 2'b00, 4'b0011, 3'b010};
    endfunction

    // Inputs change 1 time unit after the rising edge; checks run 3 units later.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_desc = '0; req1_desc = '0;
        ARREADY = 0; RID = 0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        r0_ready = 0; r1_ready = 0;
    endtask

    task automatic do_reset();
        ARESETn = 0;
        idle_inputs();
        tick();
        tick();
        ARESETn = 1;
    endtask

    initial begin
        ARESETn = 0;
        idle_inputs();
        req0_valid = 1;
        req0_desc = mk_desc(32'h0, 4'd3, 2'd1);
        #2;
        chk("rst_arvalid", 32'(ARVALID), 0);
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_cnt0", 32'(out0_cnt), 0);
        chk("rst_araddr", ARADDR, 0);
        tick();

        // Single request on port 0
        do_reset();
        req0_valid = 1;
        req0_desc = mk_desc(32'h0, 4'd3, 2'd1);
        ARREADY = 1;
        settle();
        chk("single_ready0", 32'(req0_ready), 1);
        chk("single_ready1", 32'(req1_ready), 0);
        chk("single_noarv", 32'(ARVALID), 0);
        tick();
        req0_valid = 0;
        settle();
        chk("single_arvalid", 32'(ARVALID), 1);
        chk("single_araddr", ARADDR, 32'h0);
        chk("single_arlen", 32'(ARLEN), 3);
        chk("single_arsize", 32'(ARSIZE), 1);
        chk("single_arid", 32'(ARID), 0);
        chk("single_arburst", 32'(ARBURST), 1);
        chk("single_arcache", 32'(ARCACHE), 3);
        chk("single_arprot", 32'(ARPROT), 2);
        chk("single_ready_off", 32'(req0_ready), 0);
        tick();
        settle();
        chk("single_cnt_inc", 32'(out0_cnt), 1);
        chk("single_arv_drop", 32'(ARVALID), 0);
        for (int b = 0; b < 4; b++) begin
            RVALID = 1; RID = 0; r0_ready = 1; r1_ready = 0;
            RDATA = 32'hA000 + 32'(b); RLAST = (b == 3);
            settle();
            chk("single_r0_valid", 32'(r0_valid), 1);
            chk("single_r1_valid", 32'(r1_valid), 0);
            chk("single_rready", 32'(RREADY), 1);
            chk("single_r0_data", r0_data, 32'hA000 + 32'(b));
            chk("single_cnt_hold", 32'(out0_cnt), 1);
            tick();
        end
        RVALID = 0; RLAST = 0;
        settle();
        chk("single_cnt_dec", 32'(out0_cnt), 0);

        // Tie: both ports valid from reset, expect 0,1,0,1
        do_reset();
        req0_valid = 1; req0_desc = mk_desc(32'h1000, 4'd0, 2'd2);
        req1_valid = 1; req1_desc = mk_desc(32'h2000, 4'd1, 2'd2);
        ARREADY = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("tie_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("tie_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            tick();
            settle();
            chk("tie_arvalid", 32'(ARVALID), 1);
            chk("tie_arid", 32'(ARID), 32'(i % 2));
            chk("tie_araddr", ARADDR, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            chk("tie_no_ready", 32'({req0_ready, req1_ready}), 0);
            tick();
        end
        settle();
        chk("tie_cnt0", 32'(out0_cnt), 2);
        chk("tie_cnt1", 32'(out1_cnt), 2);
        chk("tie_limit_ready", 32'({req0_ready, req1_ready}), 0);

        // Backpressure: AR outputs frozen while ARREADY is low
        do_reset();
        req1_valid = 1; req1_desc = mk_desc(32'hCAFE0, 4'd7, 2'd2);
        settle();
        chk("bp_grant1", 32'(req1_ready), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            req1_desc = mk_desc(32'h5550 + 32'(i), 4'd2, 2'd0);
            settle();
            chk("bp_arvalid", 32'(ARVALID), 1);
            chk("bp_araddr", ARADDR, 32'hCAFE0);
            chk("bp_arlen", 32'(ARLEN), 7);
            chk("bp_arid", 32'(ARID), 1);
            chk("bp_no_grant", 32'({req0_ready, req1_ready}), 0);
            tick();
        end
        ARREADY = 1;
        settle();
        chk("bp_hs_arvalid", 32'(ARVALID), 1);
        tick();
        req1_valid = 0;
        settle();
        chk("bp_cnt1", 32'(out1_cnt), 1);
        chk("bp_arv_drop", 32'(ARVALID), 0);

        // Outstanding limit on port 0
        do_reset();
        req0_valid = 1; req0_desc = mk_desc(32'h40, 4'd0, 2'd2);
        ARREADY = 1;
        settle();
        chk("lim_g1", 32'(req0_ready), 1);
        tick(); settle();
        tick(); settle();
        chk("lim_g2", 32'(req0_ready), 1);
        tick(); settle();
        tick();
        req1_valid = 1; req1_desc = mk_desc(32'h80, 4'd0, 2'd2);
        settle();
        chk("lim_cnt0", 32'(out0_cnt), 2);
        chk("lim_blocked0", 32'(req0_ready), 0);
        chk("lim_grant1", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        settle();
        chk("lim_arid1", 32'(ARID), 1);
        tick();
        RVALID = 1; RID = 0; RLAST = 1; r0_ready = 1;
        settle();
        chk("lim_still0", 32'(req0_ready), 0);
        chk("lim_rready", 32'(RREADY), 1);
        tick();
        RVALID = 0; RLAST = 0;
        settle();
        chk("lim_cnt_after", 32'(out0_cnt), 1);
        chk("lim_reenable", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        tick();

        // R routing and same-cycle increment/decrement on port 1
        do_reset();
        req1_valid = 1; req1_desc = mk_desc(32'h300, 4'd0, 2'd2);
        ARREADY = 1;
        tick();
        req1_valid = 0;
        tick();
        req1_valid = 1;
        settle();
        chk("rt_cnt1_a", 32'(out1_cnt), 1);
        chk("rt_grant1", 32'(req1_ready), 1);
        tick();
        req1_valid = 0; ARREADY = 0;
        RVALID = 1; RID = 1; RLAST = 1; RDATA = 32'h1234_5678; RRESP = 2'd2;
        r1_ready = 0; r0_ready = 1;
        settle();
        chk("rt_r1_valid", 32'(r1_valid), 1);
        chk("rt_r0_valid", 32'(r0_valid), 0);
        chk("rt_rready_lo", 32'(RREADY), 0);
        chk("rt_r1_data", r1_data, 32'h1234_5678);
        chk("rt_r1_resp", 32'(r1_resp), 2);
        tick();
        r1_ready = 1; ARREADY = 1;
        settle();
        chk("rt_cnt1_hold", 32'(out1_cnt), 1);
        chk("rt_rready_hi", 32'(RREADY), 1);
        chk("rt_arvalid", 32'(ARVALID), 1);
        tick();
        RVALID = 0; RLAST = 0; ARREADY = 0;
        settle();
        chk("rt_cnt1_same", 32'(out1_cnt), 1);
        // Completion on an idle port saturates at zero
        RVALID = 1; RID = 0; RLAST = 1; r0_ready = 1;
        tick();
        RVALID = 0; RLAST = 0;
        settle();
        chk("rt_cnt0_sat", 32'(out0_cnt), 0);

        // Reset while ISSUE is pending
        req0_valid = 1; req0_desc = mk_desc(32'h777, 4'd5, 2'd1);
        tick();
        req0_valid = 0;
        settle();
        chk("mid_arvalid", 32'(ARVALID), 1);
        ARESETn = 0;
        #1;
        chk("mid_rst_arv", 32'(ARVALID), 0);
        chk("mid_rst_cnt1", 32'(out1_cnt), 0);
        chk("mid_rst_addr", ARADDR, 0);
        tick();
        ARESETn = 1;
        req0_valid = 1; req0_desc = mk_desc(32'h10, 4'd0, 2'd0);
        req1_valid = 1; req1_desc = mk_desc(32'h20, 4'd0, 2'd0);
        ARREADY = 1;
        settle();
        chk("mid_tie_ready0", 32'(req0_ready), 1);
        chk("mid_tie_ready1", 32'(req1_ready), 0);
        tick();
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
